// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/grant/response bus between the fetch unit and the ROM.
interface if_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC generation, ROM requests, in-order prefetch FIFO.
// Optional misaligned-redirect trap enabled by defining IF_MISALIGN_CHECK_EN.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  input  logic                  id_en,
  if_fetch_unit_if.master       imem,
  output logic [31:0]           PC_IF,
  output logic [31:0]           DataInstF,
  output logic                  inst_valid,
  output logic                  fetch_fault
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int SW = CW + 1;

  logic          rst_state_q;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW-1:0] trd_q, trd_d, twr_q, twr_d;
  logic [31:0]   pc_mem_q   [FIFO_DEPTH];
  logic [31:0]   inst_mem_q [FIFO_DEPTH];
  logic [31:0]   tag_mem_q  [FIFO_DEPTH];

  logic fault_halt;
  logic credit_ok, fire, resp_keep, push, pop;

`ifdef IF_MISALIGN_CHECK_EN
  logic fault_q, fault_d;

  assign fault_d = redirect_valid ? (redirect_pc[1:0] != 2'b00) : fault_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= fault_d;
  end

  assign fault_halt  = fault_q;
  assign fetch_fault = fault_q;
`else
  logic unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign fault_halt  = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  // Credits cover both buffered and in-flight words, so the FIFO can never overflow.
  assign credit_ok = ({1'b0, count_q} + {1'b0, outst_q}) < SW'(FIFO_DEPTH);
  assign imem.req  = !rst_state_q && !fault_halt && credit_ok && !redirect_valid;
  assign imem.addr = fetch_pc_q;
  assign fire      = imem.req && imem.gnt;
  assign resp_keep = imem.rvalid && (drop_q == '0);
  assign push      = resp_keep && !redirect_valid;
  assign inst_valid = (count_q != '0);
  assign pop       = inst_valid && id_en && !redirect_valid;

  assign PC_IF     = inst_valid ? pc_mem_q[rd_q]   : 32'h0;
  assign DataInstF = inst_valid ? inst_mem_q[rd_q] : 32'h0;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    drop_d     = drop_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    trd_d      = trd_q;
    twr_d      = twr_q;
    outst_d    = outst_q + CW'(fire) - CW'(imem.rvalid);
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      count_d    = '0;
      rd_d       = '0;
      wr_d       = '0;
      trd_d      = '0;
      twr_d      = '0;
      // A response landing in the redirect cycle is stale too.
      drop_d     = outst_q - CW'(imem.rvalid);
    end else begin
      if (fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        twr_d      = twr_q + AW'(1);
      end
      if (resp_keep) trd_d = trd_q + AW'(1);
      if (imem.rvalid && (drop_q != '0)) drop_d = drop_q - CW'(1);
      if (push) wr_d = wr_q + AW'(1);
      if (pop)  rd_d = rd_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_state_q <= 1'b1;
      fetch_pc_q  <= RESET_PC;
      count_q     <= '0;
      outst_q     <= '0;
      drop_q      <= '0;
      rd_q        <= '0;
      wr_q        <= '0;
      trd_q       <= '0;
      twr_q       <= '0;
    end else begin
      rst_state_q <= 1'b0;
      fetch_pc_q  <= fetch_pc_d;
      count_q     <= count_d;
      outst_q     <= outst_d;
      drop_q      <= drop_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      trd_q       <= trd_d;
      twr_q       <= twr_d;
    end
  end

  // Storage is qualified by occupancy, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_q]   <= tag_mem_q[trd_q];
      inst_mem_q[wr_q] <= imem.rdata;
    end
    if (fire) tag_mem_q[twr_q] <= imem.addr;
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit with an in-order ROM model returning addr as data.
module tb_if_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_en = 1'b0;
  logic [31:0] PC_IF, DataInstF;
  logic        inst_valid, fetch_fault;

  if_fetch_unit_if bus();

  if_fetch_unit dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_en(id_en), .imem(bus),
    .PC_IF(PC_IF), .DataInstF(DataInstF),
    .inst_valid(inst_valid), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int grant_cnt = 0;
  int consumed = 0;
  int cyc = 0;
  int rom_lat = 1;
  bit rom_gnt_en = 1'b1;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ROM model: decides grant/response mid-cycle once requests have settled.
  always @(negedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      pend_addr.delete();
      pend_due.delete();
      bus.gnt    = 1'b0;
      bus.rvalid = 1'b0;
      bus.rdata  = 32'h0;
    end else begin
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        bus.rvalid = 1'b1;
        bus.rdata  = pend_addr[0];
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        bus.rvalid = 1'b0;
        bus.rdata  = 32'h0;
      end
      bus.gnt = rom_gnt_en;
      if (bus.req && rom_gnt_en) begin
        pend_addr.push_back(bus.addr);
        pend_due.push_back(cyc + rom_lat);
        grant_cnt++;
      end
    end
  end

  // Monitor: every head entry consumed by ID is checked against the expected stream.
  always @(negedge clk) begin
    logic [31:0] e;
    #2;
    if (!rst && inst_valid && id_en && !redirect_valid) begin
      consumed++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_extra: got pc %h want no entry", PC_IF);
      end else begin
        e = exp_q.pop_front();
        check("sb_pc", PC_IF, e);
        check("sb_inst", DataInstF, e);
      end
    end
  end

  task automatic expect_seq(input logic [31:0] start, input int n);
    logic [31:0] p;
    p = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(p);
      p = p + 32'd4;
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        id_en = 1'b0;
        return;
      end
      id_en = 1'b1;
    end
    total++;
    bad++;
    $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
    id_en = 1'b0;
    exp_q.delete();
  endtask

  task automatic redirect(input logic [31:0] pc);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  initial begin
    int first;
    repeat (3) @(negedge clk);
    #3;
    check("rst_req", 32'(bus.req), 32'h0);
    check("rst_addr", bus.addr, 32'h0);
    check("rst_valid", 32'(inst_valid), 32'h0);
    check("rst_pc", PC_IF, 32'h0);
    check("rst_inst", DataInstF, 32'h0);
    check("rst_fault", 32'(fetch_fault), 32'h0);

    // Release reset and measure first-valid latency.
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_req0", 32'(bus.req), 32'h0);
    first = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      #3;
      if (c == 1) begin
        check("first_req", 32'(bus.req), 32'h1);
        check("first_addr", bus.addr, 32'h0);
      end
      if (inst_valid) begin
        first = c;
        break;
      end
    end
    check("first_valid_lat", first, 32'd3);
    expect_seq(32'h0, 5);
    drain();

    // Stall ID: buffer fills to depth and requests stop.
    repeat (10) @(negedge clk);
    #3;
    check("stall_req", 32'(bus.req), 32'h0);
    check("stall_valid", 32'(inst_valid), 32'h1);
    check("stall_buffered", grant_cnt - consumed, 32'd2);
    expect_seq(32'h14, 4);
    drain();

    // Grant withheld: address held.
    @(negedge clk);
    rom_gnt_en     = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #3;
      check("hold_req", 32'(bus.req), 32'h1);
      check("hold_addr", bus.addr, 32'h10);
      @(negedge clk);
    end
    rom_gnt_en = 1'b1;
    #3;
    check("hold_release_addr", bus.addr, 32'h10);
    expect_seq(32'h10, 3);
    drain();

    // Two-cycle ROM turnaround, redirect with two responses in flight.
    repeat (4) @(negedge clk);
    rom_lat = 2;
    redirect(32'h40);
    @(negedge clk);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    #3;
    check("redir_req_low", 32'(bus.req), 32'h0);
    check("redir_rvalid", 32'(bus.rvalid), 32'h1);
    @(negedge clk);
    redirect_valid = 1'b0;
    #3;
    check("redir_next_req", 32'(bus.req), 32'h1);
    check("redir_next_addr", bus.addr, 32'h200);
    @(negedge clk);
    rom_lat = 1;
    expect_seq(32'h200, 3);
    drain();

    // Misaligned redirect.
    redirect(32'h102);
`ifdef IF_MISALIGN_CHECK_EN
    for (int c = 0; c < 4; c++) begin
      #3;
      check("mis_fault", 32'(fetch_fault), 32'h1);
      check("mis_halt_req", 32'(bus.req), 32'h0);
      @(negedge clk);
    end
    check("mis_no_valid", 32'(inst_valid), 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    @(negedge clk);
    redirect_valid = 1'b0;
    #3;
    check("mis_clear", 32'(fetch_fault), 32'h0);
    check("mis_resume_addr", bus.addr, 32'h300);
    expect_seq(32'h300, 3);
`else
    #3;
    check("mis_fault", 32'(fetch_fault), 32'h0);
    check("mis_align_addr", bus.addr, 32'h100);
    expect_seq(32'h100, 3);
`endif
    drain();

    // PC wrap.
    redirect(32'hFFFF_FFF8);
    expect_seq(32'hFFFF_FFF8, 4);
    drain();

    // Mid-operation reset clears outputs immediately.
    repeat (4) @(negedge clk);
    #3;
    check("pre_rst_valid", 32'(inst_valid), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(inst_valid), 32'h0);
    check("mid_rst_pc", PC_IF, 32'h0);
    check("mid_rst_req", 32'(bus.req), 32'h0);
    check("mid_rst_addr", bus.addr, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    expect_seq(32'h0, 3);
    drain();

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end

endmodule
